// File: rtl/sample_rom_fetch.sv
// Sample ROM fetcher for the Z80 sound block.
// Keeps a 16-bit byte address, fetches the addressed byte from a 64 KB
// SDRAM region and converts DAC writes to signed 16-bit PCM.
module sample_rom_fetch #(
  parameter int          ROM_AW   = 25,
  parameter int unsigned ROM_BASE = 0
) (
  input  logic              CLK_32M,
  input  logic              reset_n,
  input  logic              pause,
  input  logic [15:0]       sample_addr,
  input  logic [1:0]        sample_addr_wr,
  input  logic              sample_inc,
  input  logic [7:0]        sample_out,
  output logic [7:0]        sample_in,
  output logic              sample_ready,
  output logic [ROM_AW-1:0] rom_addr,
  output logic              rom_req,
  input  logic              rom_ack,
  input  logic [7:0]        rom_data,
  output logic [15:0]       dac_audio
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [ROM_AW-1:0] BASE_ADDR = ROM_AW'(ROM_BASE);

  state_t      state_reg;
  state_t      state_next;
  logic [15:0] addr_reg;
  logic [15:0] addr_next;
  logic [15:0] addr_loaded;
  logic        dirty_reg;
  logic        addr_change;
  logic        fetch_start;
  logic        fetch_done;
  logic        fetch_keep;

  // Each address byte lane has its own load strobe.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
      assign addr_loaded[gi*8 +: 8] = sample_addr_wr[gi] ? sample_addr[gi*8 +: 8]
                                                         : addr_reg[gi*8 +: 8];
    end
  endgenerate

  assign addr_change = sample_inc | (|sample_addr_wr);
  // Data is only usable if the address did not move at any point during the fetch.
  assign fetch_keep  = fetch_done & ~dirty_reg & ~addr_change;

  // Next address: a byte load takes priority over the increment.
  always_comb begin
    addr_next = addr_reg;
    if (|sample_addr_wr) begin
      addr_next = addr_loaded;
    end else if (sample_inc) begin
      addr_next = addr_reg + 16'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next state: launch a fetch when the address is stale, finish on ack.
  always_comb begin
    state_next  = state_reg;
    fetch_start = 1'b0;
    fetch_done  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (dirty_reg && !pause) begin
          fetch_start = 1'b1;
          state_next  = BUSY;
        end
      end
      BUSY: begin
        if (rom_ack) begin
          fetch_done = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Address register and staleness flag; an address change always re-marks dirty.
  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      addr_reg  <= 16'h0000;
      dirty_reg <= 1'b1;
    end else begin
      addr_reg <= addr_next;
      if (addr_change) begin
        dirty_reg <= 1'b1;
      end else if (fetch_start) begin
        dirty_reg <= 1'b0;
      end
    end
  end

  // SDRAM request: address captured at launch and held until ack.
  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      rom_req  <= 1'b0;
      rom_addr <= '0;
    end else if (fetch_start) begin
      rom_req  <= 1'b1;
      rom_addr <= BASE_ADDR + ROM_AW'(addr_reg);
    end else if (fetch_done) begin
      rom_req  <= 1'b0;
    end
  end

  // Returned byte and its valid flag; any address change invalidates it.
  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      sample_in    <= 8'h00;
      sample_ready <= 1'b0;
    end else begin
      if (fetch_keep) begin
        sample_in <= rom_data;
      end
      if (addr_change) begin
        sample_ready <= 1'b0;
      end else if (fetch_keep) begin
        sample_ready <= 1'b1;
      end
    end
  end

  // DAC: unsigned byte to signed PCM by flipping the sign bit.
  always_ff @(posedge CLK_32M or negedge reset_n) begin
    if (!reset_n) begin
      dac_audio <= 16'h0000;
    end else if (sample_inc) begin
      dac_audio <= {sample_out ^ 8'h80, 8'h00};
    end
  end

endmodule

// File: tb/tb_sample_rom_fetch.sv
// Testbench for sample_rom_fetch: directed vector table, hand-written
// pause / reset sequences, then randomized traffic against a reference model.
module tb_sample_rom_fetch;

  localparam int          AW   = 25;
  localparam int unsigned BASE = 32'h0004_0000;

  logic          CLK_32M = 1'b0;
  logic          reset_n = 1'b1;
  logic          pause = 1'b0;
  logic [15:0]   sample_addr = '0;
  logic [1:0]    sample_addr_wr = '0;
  logic          sample_inc = 1'b0;
  logic [7:0]    sample_out = '0;
  logic [7:0]    sample_in;
  logic          sample_ready;
  logic [AW-1:0] rom_addr;
  logic          rom_req;
  logic          rom_ack = 1'b0;
  logic [7:0]    rom_data = '0;
  logic [15:0]   dac_audio;

  sample_rom_fetch #(.ROM_AW(AW), .ROM_BASE(BASE)) dut (
    .CLK_32M(CLK_32M), .reset_n(reset_n), .pause(pause),
    .sample_addr(sample_addr), .sample_addr_wr(sample_addr_wr),
    .sample_inc(sample_inc), .sample_out(sample_out),
    .sample_in(sample_in), .sample_ready(sample_ready),
    .rom_addr(rom_addr), .rom_req(rom_req), .rom_ack(rom_ack),
    .rom_data(rom_data), .dac_audio(dac_audio)
  );

  always #5 CLK_32M = ~CLK_32M;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [1:0]  wr;
    logic [15:0] sa;
    logic        inc;
    logic [7:0]  so;
    logic        pz;
    logic        ack;
    logic [7:0]  rd;
    logic        ereq;
    logic [15:0] eoff;
    logic        erdy;
    logic [7:0]  esin;
    logic [15:0] edac;
  } vec_t;

  vec_t tbl[$];

  // Reference model: the architectural state the specification describes.
  logic [15:0] m_addr;
  logic        m_stale;      // address moved since the last launched fetch
  logic        m_inflight;   // a request is outstanding
  logic [15:0] m_off;        // offset of the outstanding / last request
  logic [7:0]  m_sin;
  logic        m_ready;
  logic [15:0] m_dac;

  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    return a[7:0] ^ {a[14:8], 1'b0} ^ a[15:8] ^ 8'h5A;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] wr, input logic [15:0] sa, input logic inc,
                       input logic [7:0] so, input logic pz, input logic ack, input logic [7:0] rd);
    sample_addr_wr = wr;
    sample_addr    = sa;
    sample_inc     = inc;
    sample_out     = so;
    pause          = pz;
    rom_ack        = ack;
    rom_data       = rd;
  endtask

  task automatic idle(input logic pz);
    drive(2'b00, 16'h0000, 1'b0, 8'h00, pz, 1'b0, 8'h00);
  endtask

  task automatic tick();
    @(posedge CLK_32M);
    @(negedge CLK_32M);
  endtask

  task automatic add(input logic [1:0] wr, input logic [15:0] sa, input logic inc,
                     input logic [7:0] so, input logic pz, input logic ack, input logic [7:0] rd,
                     input logic ereq, input logic [15:0] eoff, input logic erdy,
                     input logic [7:0] esin, input logic [15:0] edac);
    vec_t v;
    v.wr = wr; v.sa = sa; v.inc = inc; v.so = so; v.pz = pz; v.ack = ack; v.rd = rd;
    v.ereq = ereq; v.eoff = eoff; v.erdy = erdy; v.esin = esin; v.edac = edac;
    tbl.push_back(v);
  endtask

  task automatic check_req(input string name, input logic ereq, input logic [15:0] eoff);
    check({name, "_req"}, {31'd0, rom_req}, {31'd0, ereq});
    if (ereq) check({name, "_addr"}, {7'd0, rom_addr}, BASE + {16'd0, eoff});
  endtask

  // Apply one cycle's inputs to the model as the spec's rules dictate.
  task automatic model_step(input logic [1:0] wr, input logic [15:0] sa, input logic inc,
                            input logic [7:0] so, input logic pz, input logic ack,
                            input logic [7:0] rd);
    logic moved;
    logic [15:0] new_addr;
    moved    = (wr != 2'b00) || inc;
    new_addr = m_addr;
    if (wr[0]) new_addr[7:0]  = sa[7:0];
    if (wr[1]) new_addr[15:8] = sa[15:8];
    if (wr == 2'b00 && inc) new_addr = 16'((32'(m_addr) + 1) % 65536);
    if (m_inflight) begin
      if (ack) begin
        m_inflight = 1'b0;
        if (!m_stale && !moved) begin
          m_sin   = rd;
          m_ready = 1'b1;
        end
      end
    end else if (m_stale && !pz) begin
      m_inflight = 1'b1;
      m_off      = m_addr;
      m_stale    = 1'b0;
    end
    if (moved) begin
      m_stale = 1'b1;
      m_ready = 1'b0;
    end
    if (inc) m_dac = {~so[7], so[6:0], 8'h00};
    m_addr = new_addr;
  endtask

  initial begin
    logic [1:0]  wr;
    logic [15:0] sa;
    logic        inc, pz, ack;
    logic [7:0]  so, rd;

    // Directed table: inputs before an edge, expected outputs after it.
    //   wr     sa        inc   so     pz    ack   rd       req  off       rdy  sin    dac
    add(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00,   1'b1, 16'h0000, 1'b0, 8'h00, 16'h0000);
    add(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00,   1'b1, 16'h0000, 1'b0, 8'h00, 16'h0000);
    add(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00,   1'b1, 16'h0000, 1'b0, 8'h00, 16'h0000);
    add(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A,   1'b0, 16'h0000, 1'b1, 8'h5A, 16'h0000);
    add(2'b01, 16'h0034, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00,   1'b0, 16'h0000, 1'b0, 8'h5A, 16'h0000);
    add(2'b10, 16'h1200, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00,   1'b1, 16'h0034, 1'b0, 8'h5A, 16'h0000);
    add(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h11,   1'b0, 16'h0034, 1'b0, 8'h5A, 16'h0000);
    add(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00,   1'b1, 16'h1234, 1'b0, 8'h5A, 16'h0000);
    add(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h77,   1'b0, 16'h1234, 1'b1, 8'h77, 16'h0000);
    add(2'b11, 16'hFFFF, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00,   1'b0, 16'h0000, 1'b0, 8'h77, 16'h0000);
    add(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00,   1'b1, 16'hFFFF, 1'b0, 8'h77, 16'h0000);
    add(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h99,   1'b0, 16'hFFFF, 1'b1, 8'h99, 16'h0000);
    add(2'b00, 16'h0000, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00,   1'b0, 16'h0000, 1'b0, 8'h99, 16'h8000);
    add(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00,   1'b1, 16'h0000, 1'b0, 8'h99, 16'h8000);
    add(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h42,   1'b0, 16'h0000, 1'b1, 8'h42, 16'h8000);
    add(2'b11, 16'hABCD, 1'b1, 8'hFF, 1'b0, 1'b0, 8'h00,   1'b0, 16'h0000, 1'b0, 8'h42, 16'h7F00);
    add(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00,   1'b1, 16'hABCD, 1'b0, 8'h42, 16'h7F00);
    add(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h3C,   1'b0, 16'hABCD, 1'b1, 8'h3C, 16'h7F00);
    add(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'hEE,   1'b0, 16'hABCD, 1'b1, 8'h3C, 16'h7F00);
    add(2'b00, 16'h0000, 1'b1, 8'h80, 1'b0, 1'b0, 8'h00,   1'b0, 16'h0000, 1'b0, 8'h3C, 16'h0000);
    add(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00,   1'b1, 16'hABCE, 1'b0, 8'h3C, 16'h0000);
    add(2'b01, 16'h0010, 1'b0, 8'h00, 1'b0, 1'b1, 8'h55,   1'b0, 16'hABCE, 1'b0, 8'h3C, 16'h0000);
    add(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00,   1'b1, 16'hAB10, 1'b0, 8'h3C, 16'h0000);
    add(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h66,   1'b0, 16'hAB10, 1'b1, 8'h66, 16'h0000);

    // Reset state.
    #2 reset_n = 1'b0;
    tick();
    check("rst_req",   {31'd0, rom_req}, 32'd0);
    check("rst_addr",  {7'd0, rom_addr}, 32'd0);
    check("rst_ready", {31'd0, sample_ready}, 32'd0);
    check("rst_sin",   {24'd0, sample_in}, 32'd0);
    check("rst_dac",   {16'd0, dac_audio}, 32'd0);
    tick();
    reset_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].wr, tbl[i].sa, tbl[i].inc, tbl[i].so, tbl[i].pz, tbl[i].ack, tbl[i].rd);
      tick();
      $display("vec %0d: req=%0d addr=%0h ready=%0d sin=%0h dac=%0h",
               i, rom_req, rom_addr, sample_ready, sample_in, dac_audio);
      check_req($sformatf("vec%0d", i), tbl[i].ereq, tbl[i].eoff);
      check($sformatf("vec%0d_ready", i), {31'd0, sample_ready}, {31'd0, tbl[i].erdy});
      check($sformatf("vec%0d_sin", i),   {24'd0, sample_in},    {24'd0, tbl[i].esin});
      check($sformatf("vec%0d_dac", i),   {16'd0, dac_audio},    {16'd0, tbl[i].edac});
    end

    // Pause blocks launching but not an in-flight fetch.
    drive(2'b11, 16'h2222, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    tick();
    check_req("pause_load", 1'b0, 16'h0000);
    for (int k = 0; k < 3; k++) begin
      idle(1'b1);
      tick();
      check_req($sformatf("pause_hold%0d", k), 1'b0, 16'h0000);
    end
    idle(1'b0);
    tick();
    check_req("pause_fall", 1'b1, 16'h2222);
    idle(1'b1);
    tick();
    check_req("pause_busy", 1'b1, 16'h2222);
    drive(2'b00, 16'h0000, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5);
    tick();
    check_req("pause_ack", 1'b0, 16'h0000);
    check("pause_ready", {31'd0, sample_ready}, 32'd1);
    check("pause_sin",   {24'd0, sample_in}, 32'h0000_00A5);
    idle(1'b0);
    tick();
    check_req("pause_norefetch", 1'b0, 16'h0000);

    // Reset during a fetch drops the request at once; a stray ack is ignored.
    drive(2'b11, 16'h0500, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00);
    tick();
    idle(1'b0);
    tick();
    check_req("mid_busy", 1'b1, 16'h0500);
    reset_n = 1'b0;
    #1;
    check("mid_rst_req",   {31'd0, rom_req}, 32'd0);
    check("mid_rst_ready", {31'd0, sample_ready}, 32'd0);
    drive(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'hCC);
    tick();
    check("mid_stray_req", {31'd0, rom_req}, 32'd0);
    idle(1'b0);
    reset_n = 1'b1;
    tick();
    check_req("mid_refetch", 1'b1, 16'h0000);
    check("mid_refetch_ready", {31'd0, sample_ready}, 32'd0);
    drive(2'b00, 16'h0000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h5A);
    tick();
    check("mid_done_ready", {31'd0, sample_ready}, 32'd1);
    check("mid_done_sin",   {24'd0, sample_in}, 32'h0000_005A);

    // Randomized traffic from a fresh reset, checked against the model.
    idle(1'b0);
    reset_n = 1'b0;
    tick();
    reset_n    = 1'b1;
    m_addr     = 16'h0000;
    m_stale    = 1'b1;
    m_inflight = 1'b0;
    m_off      = 16'h0000;
    m_sin      = 8'h00;
    m_ready    = 1'b0;
    m_dac      = 16'h0000;
    for (int c = 0; c < 1500; c++) begin
      wr  = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      sa  = 16'($urandom);
      inc = ($urandom_range(0, 7) == 0);
      so  = 8'($urandom);
      pz  = ($urandom_range(0, 4) == 0);
      if (m_inflight) begin
        ack = ($urandom_range(0, 2) == 0);
        rd  = rom_byte(m_off);
      end else begin
        ack = ($urandom_range(0, 19) == 0);
        rd  = 8'($urandom);
      end
      drive(wr, sa, inc, so, pz, ack, rd);
      @(posedge CLK_32M);
      model_step(wr, sa, inc, so, pz, ack, rd);
      @(negedge CLK_32M);
      if (ack && rom_req === 1'b0 && m_inflight === 1'b0 && m_ready)
        $display("rnd %0d: fetch %0h -> %0h", c, m_off, m_sin);
      check_req($sformatf("rnd%0d", c), m_inflight, m_off);
      check($sformatf("rnd%0d_ready", c), {31'd0, sample_ready}, {31'd0, m_ready});
      check($sformatf("rnd%0d_sin", c),   {24'd0, sample_in},    {24'd0, m_sin});
      check($sformatf("rnd%0d_dac", c),   {16'd0, dac_audio},    {16'd0, m_dac});
      if (m_ready)
        check($sformatf("rnd%0d_romdata", c), {24'd0, sample_in}, {24'd0, rom_byte(m_addr)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sample_rom_fetch.md
SAMPLE_ROM_FETCH -- requirements
Module: sample_rom_fetch

Interface
REQ-001 Parameter ROM_AW, default 25, SHALL set the width of the SDRAM byte-address bus.
REQ-002 Parameter ROM_BASE, default 0, SHALL be the SDRAM byte offset of the 64 KB sample ROM region.
REQ-003 CLK_32M  in  1  SHALL be the single system clock; every register is clocked on its rising edge.
REQ-004 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 pause  in  1  SHALL be the high level that blocks new ROM fetches.
REQ-006 sample_addr  in  16  SHALL carry the address byte lanes from the Z80 sound block.
REQ-007 sample_addr_wr  in  2  SHALL be a one-cycle strobe per lane: bit0 loads the low byte, bit1 loads the high byte.
REQ-008 sample_inc  in  1  SHALL be a one-cycle strobe meaning: DAC write plus address increment.
REQ-009 sample_out  in  8  SHALL be the unsigned DAC byte, qualified by sample_inc.
REQ-010 sample_in  out  8  SHALL be the ROM byte at the current address.
REQ-011 sample_ready  out  1  SHALL be high when sample_in matches the current address.
REQ-012 rom_addr  out  ROM_AW  SHALL be the SDRAM byte address.
REQ-013 rom_req  out  1  SHALL be the level read request.
REQ-014 rom_ack  in  1  SHALL be a one-cycle completion strobe with rom_data valid.
REQ-015 rom_data  in  8  SHALL be the SDRAM read data.
REQ-016 dac_audio  out  16  SHALL be the signed PCM DAC output.

Function
REQ-017 The 16-bit address register addr SHALL load addr[7:0] from sample_addr[7:0] when sample_addr_wr[0]=1, and addr[15:8] from sample_addr[15:8] when sample_addr_wr[1]=1; both bits in one cycle SHALL load both bytes.
REQ-018 When sample_inc=1 and sample_addr_wr=00, addr SHALL become addr+1 mod 2^16 (0xFFFF wraps to 0x0000).
REQ-019 When sample_inc=1 and any sample_addr_wr bit=1 in the same cycle, the load SHALL win and the increment SHALL be dropped; the DAC update still SHALL occur.
REQ-020 When sample_inc=1, dac_audio SHALL become {sample_out^8'h80, 8'h00} on the next edge; otherwise it SHALL hold.
REQ-021 Any cycle that loads or increments addr SHALL set flag dirty and clear sample_ready on the next edge.
REQ-022 The FSM SHALL have two states: IDLE and BUSY.
REQ-023 In IDLE with dirty=1 and pause=0, the FSM SHALL on the next edge set rom_req=1, set rom_addr=ROM_BASE+addr (zero-extended), clear dirty, and enter BUSY.
REQ-024 In BUSY, rom_req and rom_addr SHALL hold until rom_ack.
REQ-025 On rom_ack in BUSY, the FSM SHALL clear rom_req and return to IDLE on the next edge.
REQ-026 On rom_ack in BUSY with dirty=0 and no addr change in the same cycle, sample_in SHALL load rom_data and sample_ready SHALL set.
REQ-027 On rom_ack in BUSY when addr changed during the fetch (dirty=1 or a change in the ack cycle), rom_data SHALL be discarded and sample_ready SHALL stay 0; IDLE then SHALL reissue the fetch for the new addr.
REQ-028 Minimum latency SHALL be: addr change at edge N, rom_req high after edge N+1, sample_ready high one edge after the rom_ack cycle.
REQ-029 rom_ack in IDLE SHALL be ignored.
REQ-030 pause SHALL not abort a BUSY fetch; it only blocks the IDLE->BUSY transition; address/DAC strobes SHALL still be honoured.

Reset
REQ-031 reset_n=0 SHALL asynchronously set: addr=0, dirty=1, state=IDLE, rom_req=0, rom_addr=0, sample_in=0, sample_ready=0, dac_audio=0.
REQ-032 After release with pause=0, the block SHALL fetch address 0 automatically.
REQ-033 Reset asserted mid-fetch SHALL drop rom_req immediately; a later stray rom_ack SHALL be ignored.

Verification
REQ-034 Release reset, ROM[0x0000]=0x5A, ack after 3 cycles -> rom_req rises 1 edge after release, rom_addr=ROM_BASE, then sample_in=0x5A and sample_ready=1.
REQ-035 wr=01 with 0x34, then wr=10 with 0x12 -> final fetch at ROM_BASE+0x1234, earlier data discarded, sample_ready=1 only after the 0x1234 ack.
REQ-036 addr=0xFFFF, sample_inc with sample_out=0x00 -> dac_audio=0x8000, addr=0x0000, fetch issued at ROM_BASE.
REQ-037 sample_inc and wr=11 (0xABCD) in the same cycle, sample_out=0xFF -> addr=0xABCD (no increment), dac_audio=0x7F00.
REQ-038 pause=1 with dirty set -> rom_req stays 0 until pause falls; a BUSY fetch started before pause completes normally.
REQ-039 Assert reset_n low while BUSY, then pulse rom_ack -> rom_req=0 immediately, ack ignored, fetch of address 0 follows release.
